// File: rtl/alu_seq.sv
// Handshaked ALU: one-hot ops, single-cycle logic/arith plus bit-serial shifts.
// Define ALU_MUL_EN to add a bit-serial unsigned shift-add multiplier (op bit 8).
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [WIDTH-1:0] iOperandA,
  input  logic [WIDTH-1:0] iOperandB,
  input  logic [8:0]       iOperation,
  input  logic             iValid,
  output logic             oReady,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oAluResult,
  output logic             oZero,
  output logic             oCarry,
  output logic             oNegative,
  output logic             oOverflow,
  output logic             oError
);

  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {K_SL, K_SR, K_MUL} kind_t;

  state_t           state_q, state_d;
  kind_t            kind_q, kind_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

`ifdef ALU_MUL_EN
  localparam logic MUL_EN = 1'b1;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_step;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  logic             accept;
  logic             op_onehot;
  logic             op_legal;
  logic [WIDTH:0]   add_sum;
  logic [SHW-1:0]   shamt;

  assign oReady     = (state_q == S_IDLE) && iReset;
  assign oValid     = (state_q == S_DONE);
  assign oAluResult = result_q;
  assign oZero      = zero_q;
  assign oCarry     = carry_q;
  assign oNegative  = neg_q;
  assign oOverflow  = ovf_q;
  assign oError     = err_q;

  assign accept    = iValid && oReady;
  assign op_onehot = (iOperation != 9'd0) && ((iOperation & (iOperation - 9'd1)) == 9'd0);
  assign op_legal  = op_onehot && (MUL_EN || !iOperation[8]);
  assign add_sum   = {1'b0, iOperandA} + {1'b0, iOperandB};
  assign shamt     = iOperandB[SHW-1:0];

`ifdef ALU_MUL_EN
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    count_d  = count_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_DONE;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          if (!op_legal) begin
            result_d = '0;
            err_d    = 1'b1;
          end else if (iOperation[0]) begin
            result_d = add_sum[WIDTH-1:0];
            carry_d  = add_sum[WIDTH];
            ovf_d    = (iOperandA[WIDTH-1] == iOperandB[WIDTH-1]) &&
                       (add_sum[WIDTH-1] != iOperandA[WIDTH-1]);
          end else if (iOperation[1]) begin
            result_d = iOperandA & iOperandB;
          end else if (iOperation[2]) begin
            result_d = iOperandA | iOperandB;
          end else if (iOperation[3]) begin
            result_d = ~iOperandA;
          end else if (iOperation[4]) begin
            result_d = iOperandA ^ iOperandB;
          end else if (iOperation[5] || iOperation[6]) begin
            // result_q doubles as the shift working register
            result_d = iOperandA;
            kind_d   = iOperation[5] ? K_SL : K_SR;
            count_d  = {1'b0, shamt};
            if (shamt != '0) state_d = S_SHIFT;
          end else if (iOperation[7]) begin
            result_d = {{(WIDTH-1){1'b0}}, (iOperandA == iOperandB)};
`ifdef ALU_MUL_EN
          end else begin
            kind_d   = K_MUL;
            count_d  = CW'(WIDTH);
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, iOperandA};
            mplier_d = iOperandB;
            state_d  = S_SHIFT;
`endif
          end
        end
      end

      S_SHIFT: begin
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = S_DONE;
        unique case (kind_q)
          K_SL: begin
            carry_d  = result_q[WIDTH-1];
            result_d = result_q << 1;
          end
          K_SR: begin
            carry_d  = result_q[0];
            result_d = result_q >> 1;
          end
          default: begin
`ifdef ALU_MUL_EN
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            result_d = acc_step[WIDTH-1:0];
            carry_d  = |acc_step[2*WIDTH-1:WIDTH];
`endif
          end
        endcase
      end

      S_DONE: begin
        if (iReady) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Zero/negative always track the result; they only matter while oValid is high
    zero_d = (result_d == '0);
    neg_d  = result_d[WIDTH-1];
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state_q  <= S_IDLE;
      kind_q   <= K_SL;
      count_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      count_q  <= count_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq plus hand-written back-pressure and
// reset-abort sequences; expectations follow ALU_MUL_EN when it is defined.
module tb_alu_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  op_a, op_b;
  logic [8:0]    op;
  logic          in_valid, out_ready;
  logic          dut_ready, dut_valid;
  logic [W-1:0]  dut_result;
  logic          dut_zero, dut_carry, dut_neg, dut_ovf, dut_err;

  int checks   = 0;
  int failures = 0;

  localparam logic [8:0] OP_ADD = 9'd1,  OP_AND = 9'd2,  OP_OR  = 9'd4;
  localparam logic [8:0] OP_NOT = 9'd8,  OP_XOR = 9'd16, OP_SL  = 9'd32;
  localparam logic [8:0] OP_SR  = 9'd64, OP_CMP = 9'd128, OP_MUL = 9'd256;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .iClock(clk), .iReset(rst_n), .iOperandA(op_a), .iOperandB(op_b),
    .iOperation(op), .iValid(in_valid), .oReady(dut_ready), .oValid(dut_valid),
    .iReady(out_ready), .oAluResult(dut_result), .oZero(dut_zero),
    .oCarry(dut_carry), .oNegative(dut_neg), .oOverflow(dut_ovf), .oError(dut_err)
  );

  typedef struct {
    logic [8:0]   op;
    logic [W-1:0] a, b, res;
    logic         z, c, n, v, e;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [8:0] o, logic [W-1:0] a, logic [W-1:0] b,
                              logic [W-1:0] r, logic z, logic c, logic n,
                              logic v, logic e, int lat);
    vec_t t;
    t.op = o; t.a = a; t.b = b; t.res = r;
    t.z = z; t.c = c; t.n = n; t.v = v; t.e = e; t.lat = lat;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one op, measure latency to oValid, compare outputs, then release.
  task automatic run_vec(input int idx, input vec_t t);
    int cyc;
    @(negedge clk);
    chk($sformatf("v%0d ready", idx), 32'(dut_ready), 32'd1);
    op_a = t.a; op_b = t.b; op = t.op; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!dut_valid && cyc < 40);
    chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(t.lat));
    chk($sformatf("v%0d result", idx), 32'(dut_result), 32'(t.res));
    chk($sformatf("v%0d flags zcnve", idx),
        32'({dut_zero, dut_carry, dut_neg, dut_ovf, dut_err}),
        32'({t.z, t.c, t.n, t.v, t.e}));
    $display("vec %0d op=%09b a=%04h b=%04h -> res=%04h zcnve=%b%b%b%b%b lat=%0d",
             idx, t.op, t.a, t.b, dut_result, dut_zero, dut_carry, dut_neg,
             dut_ovf, dut_err, cyc);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d idle after take", idx), 32'({dut_valid, dut_ready}), 32'b01);
  endtask

  initial begin
    rst_n = 1'b0; op_a = '0; op_b = '0; op = '0; in_valid = 1'b0; out_ready = 1'b0;

    vecs.push_back(mk(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_NOT, 16'h00FF, 16'h1234, 16'hFF00, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(OP_CMP, 16'h1234, 16'h1234, 16'h0001, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_CMP, 16'h1234, 16'h1235, 16'h0000, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SL,  16'h8001, 16'h0003, 16'h0008, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(OP_SR,  16'h0001, 16'h0000, 16'h0001, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SR,  16'h0003, 16'h0002, 16'h0000, 1, 1, 0, 0, 0, 3));
    vecs.push_back(mk(OP_SL,  16'h8000, 16'h0001, 16'h0000, 1, 1, 0, 0, 0, 2));
    vecs.push_back(mk(OP_SL,  16'h0001, 16'h000F, 16'h8000, 0, 0, 1, 0, 0, 16));
    vecs.push_back(mk(OP_SL,  16'h0001, 16'hFFF3, 16'h0008, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(9'b000000011, 16'h1111, 16'h2222, 16'h0000, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(9'b000000000, 16'h1111, 16'h2222, 16'h0000, 1, 0, 0, 0, 1, 1));
`ifdef ALU_MUL_EN
    vecs.push_back(mk(OP_MUL, 16'd300, 16'd300, 16'h5F90, 0, 1, 0, 0, 0, 17));
    vecs.push_back(mk(OP_MUL, 16'd3,   16'd5,   16'h000F, 0, 0, 0, 0, 0, 17));
`else
    vecs.push_back(mk(OP_MUL, 16'd300, 16'd300, 16'h0000, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(OP_MUL, 16'd3,   16'd5,   16'h0000, 1, 0, 0, 0, 1, 1));
`endif

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset valid/ready", 32'({dut_valid, dut_ready}), 32'b00);
    chk("reset result", 32'(dut_result), 32'd0);
    chk("reset flags", 32'({dut_zero, dut_carry, dut_neg, dut_ovf, dut_err}), 32'd0);
    $display("reset: valid=%b ready=%b result=%04h", dut_valid, dut_ready, dut_result);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Back-pressure: result held while the consumer stalls, new iValid ignored
    @(negedge clk);
    op_a = 16'hAAAA; op_b = 16'hFFFF; op = OP_XOR; in_valid = 1'b1;
    @(posedge clk);
    #1 op_a = 16'h0001; op_b = 16'h0001; op = OP_ADD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d valid/ready", i), 32'({dut_valid, dut_ready}), 32'b10);
      chk($sformatf("bp%0d result", i), 32'(dut_result), 32'h5555);
      $display("backpressure cycle %0d: valid=%b ready=%b result=%04h",
               i, dut_valid, dut_ready, dut_result);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp release idle", 32'({dut_valid, dut_ready}), 32'b01);
    repeat (3) @(negedge clk);
    chk("bp no stray result", 32'(dut_valid), 32'd0);
    $display("backpressure release: valid=%b ready=%b", dut_valid, dut_ready);

    // Reset asserted mid-shift aborts the op
    @(negedge clk);
    op_a = 16'h0001; op_b = 16'h000F; op = OP_SL; in_valid = 1'b1;
    @(posedge clk);          // edge k
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;         // sampled at edge k+5
    @(negedge clk);
    @(negedge clk);
    chk("abort in reset valid/ready", 32'({dut_valid, dut_ready}), 32'b00);
    chk("abort in reset result", 32'(dut_result), 32'd0);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (dut_valid) seen++;
      end
      chk("abort no result", 32'(seen), 32'd0);
    end
    chk("abort idle", 32'(dut_ready), 32'd1);
    $display("abort: valid=%b ready=%b", dut_valid, dut_ready);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
